instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage that sits directly upstream of `processor` and drives its 4-bit `instruction` input. A small loadable program memory is written while idle. On `start`, the block issues a program of a given length, one word per clock, with stall support. Whenever it is not issuing, it drives NOP (`4'b0000`), so the processor, which has no valid input, always sees a harmless opcode.

## Interface
- `DEPTH`, 16: program memory words.
- `PC_W`, 4: address width; `DEPTH == 2**PC_W`.
- `INSTR_W`, 4: instruction width; must match `processor`.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `prog_we`  in  1: program memory write strobe; honoured in IDLE only.
- `prog_addr`  in  PC_W: write address.
- `prog_data`  in  INSTR_W: write data.
- `prog_len`  in  PC_W+1: number of words to issue; sampled on an accepted `start`.
- `start`  in  1: begin issuing; honoured in IDLE only.
- `stall`  in  1: hold issue for this cycle.
- `instruction`  out  INSTR_W: registered; connects to `processor.instruction`.
- `instr_valid`  out  1: registered; high when `instruction` is a program word.
- `pc`  out  PC_W: address of the next word to issue.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse after the last word is issued.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE
  - `prog_we` writes `mem[prog_addr] <= prog_data`.
  - `start` with `prog_len != 0` latches `len_q = min(prog_len, DEPTH)`, clears the issue counter `cnt` (PC_W+1 bits) and moves to RUN.
  - `start` with `prog_len == 0` is ignored.
- RUN
  - If `stall = 0`: `instruction <= mem[cnt[PC_W-1:0]]`, `instr_valid <= 1`, `cnt <= cnt + 1`.
  - If `stall = 1`: `instruction <= 4'b0000`, `instr_valid <= 0`, `cnt` holds.
  - On the non-stalled edge that issues word `len_q-1`, the FSM moves to DONE.
- DONE
  - Lasts one cycle.
  - `instruction <= 0000`, `instr_valid <= 0`, `done <= 1`; the next edge returns the FSM to IDLE.
- Outputs derived from state and counter:
  - `pc = cnt[PC_W-1:0]`.
  - `busy = (state == RUN)`.
- In RUN and DONE, `prog_we` and `start` are ignored. The memory is locked during issue.
- Simultaneous `prog_we` and `start` in IDLE: both are accepted. The write is visible to the first fetch, because the fetch occurs no earlier than the next edge.
- Wrap-around: with `len_q = DEPTH`, `pc` runs 0..15. The final increment wraps `pc` to 0 while the FSM leaves RUN. No word is ever issued twice.
- `rst`
  - Sets state = IDLE, `cnt = 0`, `len_q = 0`, `instruction = 0000`, `instr_valid = 0`, `done = 0`.
  - `busy = 0` and `pc = 0` follow from this.
  - Memory contents are not reset; they persist across `rst`.
  - A reset asserted mid-RUN aborts issue at that edge.

## Timing
- `start` accepted at edge k: the FSM is in RUN after edge k.
- The first word is on `instruction`, with `instr_valid = 1`, after edge k+1 if not stalled.
- One word per non-stalled cycle; an N-word program with S stall cycles occupies N+S cycles in RUN.
- `done` is high for exactly the one cycle after the last word is presented. `busy` is low in that cycle.
- A new `start` is accepted no earlier than the edge following the DONE cycle, i.e. once the FSM is back in IDLE.
- Memory write has 1-cycle latency: a word written at edge k is readable at edge k+1.

## Structure
- Shared package `proc_pkg` holds:
  - `INSTR_W`.
  - Opcode constants `OP_NOP=0000`, `OP_ADD=0001`, `OP_SUB=0010`, `OP_AND=0011`, `OP_OR=0100`, `OP_LOAD=0101`, `OP_STORE=0110`, `OP_MOV=0111`.
  - The FSM state enum.
- `instr_fetch` drives `OP_NOP` from the package, not a literal.
- One sub-module, `prog_mem`: DEPTH×INSTR_W storage with synchronous write and asynchronous read, no reset.

## Test plan
- Reset: pulse `rst` → `instruction = 0000`, `instr_valid = 0`, `busy = 0`, `done = 0`, `pc = 0`.
- Full opcode program:
  - Stimulus: write 0001, 0010, 0011, 0100, 0110, 0101, 0111, 0000 to addresses 0–7; `prog_len = 8`; `start`.
  - Response: 8 consecutive valid cycles with exactly those words; `pc` steps 1..8 (bit-truncated); `done` pulses once, then IDLE.
- Stall:
  - Stimulus: program 0001, 0010, 0011, `len = 3`; `stall = 1` for the cycle after 0001 issues.
  - Response: 0001, then 0000 with `valid = 0` while `pc` holds at 1, then 0010, then 0011, then `done`.
- Depth and clamp:
  - `len = 16` → 16 issues, `pc` wraps to 0, `done`.
  - `len = 20` → identical result (clamped to 16).
  - `len = 0` with `start` → stays IDLE, no `done`.
- Reset mid-run:
  - Stimulus: assert `rst` after 2 words of an 8-word program.
  - Response: next cycle is NOP, IDLE, `busy = 0`.
  - A re-`start` replays from `mem[0]` with the original contents intact.
- Lockout:
  - `prog_we` to addr 2 with data 1111 during RUN → a later run still issues the original word.
  - `start` during RUN → no restart.
  - `start` in the DONE cycle → ignored.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the processor front end: instruction width,
// opcode encodings and the fetch-stage state type.
package proc_pkg;

    localparam int INSTR_W = 4;

    localparam logic [INSTR_W-1:0] OP_NOP   = 4'b0000;
    localparam logic [INSTR_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [INSTR_W-1:0] OP_SUB   = 4'b0010;
    localparam logic [INSTR_W-1:0] OP_AND   = 4'b0011;
    localparam logic [INSTR_W-1:0] OP_OR    = 4'b0100;
    localparam logic [INSTR_W-1:0] OP_LOAD  = 4'b0101;
    localparam logic [INSTR_W-1:0] OP_STORE = 4'b0110;
    localparam logic [INSTR_W-1:0] OP_MOV   = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Program-load, control and issue signals of the instruction fetch stage.
// master: the controller / program loader; slave: instr_fetch.
interface instr_fetch_if #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 4
);
    logic               prog_we;
    logic [PC_W-1:0]    prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic [PC_W:0]      prog_len;
    logic               start;
    logic               stall;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic [PC_W-1:0]    pc;
    logic               busy;
    logic               done;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len, start, stall,
        input  instruction, instr_valid, pc, busy, done
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len, start, stall,
        output instruction, instr_valid, pc, busy, done
    );
endinterface

// File: rtl/instr_fetch_prog_mem.sv
// Program memory: synchronous write, asynchronous read, contents survive reset.
module prog_mem #(
    parameter int DEPTH   = 16,
    parameter int PC_W    = 4,
    parameter int INSTR_W = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PC_W-1:0]    waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [PC_W-1:0]    raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Write port; no reset so a loaded program persists across rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: loads a program while idle, then issues it one
// word per non-stalled cycle, driving NOP whenever nothing is being issued.
module instr_fetch #(
    parameter int DEPTH   = 16,
    parameter int PC_W    = 4,
    parameter int INSTR_W = proc_pkg::INSTR_W
) (
    input logic          clk,
    input logic          rst,
    instr_fetch_if.slave bus
);
    import proc_pkg::*;

    localparam logic [PC_W:0] DEPTH_L = (PC_W + 1)'(DEPTH);

    fetch_state_e       state_q, state_d;
    logic [PC_W:0]      cnt_q, cnt_d;
    logic [PC_W:0]      len_q, len_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               mem_we;
    logic [INSTR_W-1:0] rd_data;

    prog_mem #(
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .INSTR_W(INSTR_W)
    ) u_prog_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(bus.prog_addr),
        .wdata(bus.prog_data),
        .raddr(cnt_q[PC_W-1:0]),
        .rdata(rd_data)
    );

    // Next-state and next-output logic; outputs default to an idle NOP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        instr_d = OP_NOP;
        valid_d = 1'b0;
        done_d  = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                mem_we = bus.prog_we;
                if (bus.start && (bus.prog_len != '0)) begin
                    len_d   = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    instr_d = rd_data;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    // cnt is one bit wider than pc, so len_q == DEPTH ends cleanly.
                    if ((cnt_q + 1'b1) == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            instr_q <= OP_NOP;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.done        = done_q;
    assign bus.pc          = cnt_q[PC_W-1:0];
    assign bus.busy        = (state_q == ST_RUN);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: reset, table-driven stall sequence, directed
// corner cases and randomized programs checked against an issue-stream model.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    instr_fetch_if #(.PC_W(4), .INSTR_W(4)) bus ();

    instr_fetch #(
        .DEPTH  (16),
        .PC_W   (4),
        .INSTR_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [3:0]  exp_mem [16];

    typedef struct {
        logic       stall;
        logic [3:0] instr;
        logic       valid;
        logic [3:0] pc;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [3:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        step();
        bus.prog_we = 1'b0;
        exp_mem[a]  = d;
    endtask

    // Issue model: the program is the first min(len,16) words of memory, one
    // per non-stalled cycle; done follows one cycle after the last word.
    task automatic do_run(input int plen, input int stall_pct, input bit lock, input bit wr_with_start);
        int n;
        int issued;
        int guard;
        logic st;
        logic [3:0] wd;
        n = (plen > 16) ? 16 : plen;
        bus.start    = 1'b1;
        bus.prog_len = 5'(plen);
        if (wr_with_start) begin
            wd            = 4'($urandom);
            bus.prog_we   = 1'b1;
            bus.prog_addr = 4'd0;
            bus.prog_data = wd;
            exp_mem[0]    = wd;
        end
        step();
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
        if (n == 0) begin
            repeat (3) begin
                chk("len0_busy", 32'(bus.busy), 0);
                chk("len0_done", 32'(bus.done), 0);
                chk("len0_valid", 32'(bus.instr_valid), 0);
                step();
            end
            return;
        end
        chk("run_busy0", 32'(bus.busy), 1);
        chk("run_valid0", 32'(bus.instr_valid), 0);
        chk("run_instr0", 32'(bus.instruction), 0);
        chk("run_pc0", 32'(bus.pc), 0);
        issued = 0;
        guard  = 0;
        while (issued < n && guard < 200) begin
            st = ($urandom_range(99) < stall_pct);
            bus.stall = st;
            if (lock) begin
                bus.start     = 1'($urandom);
                bus.prog_len  = 5'($urandom_range(1, 16));
                bus.prog_we   = 1'b1;
                bus.prog_addr = (guard == 0) ? 4'd2 : 4'($urandom);
                bus.prog_data = (guard == 0) ? 4'hf : 4'($urandom);
            end
            step();
            if (st) begin
                chk("stall_valid", 32'(bus.instr_valid), 0);
                chk("stall_instr", 32'(bus.instruction), 0);
                chk("stall_pc", 32'(bus.pc), 32'(issued % 16));
                chk("stall_busy", 32'(bus.busy), 1);
            end else begin
                chk("issue_instr", 32'(bus.instruction), 32'(exp_mem[issued]));
                chk("issue_valid", 32'(bus.instr_valid), 1);
                issued++;
                chk("issue_pc", 32'(bus.pc), 32'(issued % 16));
                chk("issue_busy", 32'(bus.busy), (issued < n) ? 1 : 0);
                chk("issue_done", 32'(bus.done), 0);
            end
            guard++;
        end
        chk("run_bound", 32'(issued), 32'(n));
        bus.stall   = 1'b0;
        bus.prog_we = 1'b0;
        // start held through the DONE cycle must not restart issue
        bus.start    = 1'b1;
        bus.prog_len = 5'd8;
        step();
        chk("done_pulse", 32'(bus.done), 1);
        chk("done_busy", 32'(bus.busy), 0);
        chk("done_valid", 32'(bus.instr_valid), 0);
        chk("done_instr", 32'(bus.instruction), 0);
        chk("done_pc", 32'(bus.pc), 32'(n % 16));
        bus.start = 1'b0;
        step();
        chk("done_once", 32'(bus.done), 0);
        chk("idle_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.prog_len  = '0;
        bus.start     = 1'b0;
        bus.stall     = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_instr", 32'(bus.instruction), 0);
        chk("rst_valid", 32'(bus.instr_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_pc", 32'(bus.pc), 0);
        rst = 1'b0;
        step();

        // Full opcode program
        write_mem(4'd0, 4'b0001);
        write_mem(4'd1, 4'b0010);
        write_mem(4'd2, 4'b0011);
        write_mem(4'd3, 4'b0100);
        write_mem(4'd4, 4'b0110);
        write_mem(4'd5, 4'b0101);
        write_mem(4'd6, 4'b0111);
        write_mem(4'd7, 4'b0000);
        do_run(8, 0, 1'b0, 1'b0);

        // Table-driven stall sequence on a 3-word program
        write_mem(4'd0, 4'b0001);
        write_mem(4'd1, 4'b0010);
        write_mem(4'd2, 4'b0011);
        tbl[0] = '{stall: 1'b0, instr: 4'b0001, valid: 1'b1, pc: 4'd1, busy: 1'b1, done: 1'b0};
        tbl[1] = '{stall: 1'b1, instr: 4'b0000, valid: 1'b0, pc: 4'd1, busy: 1'b1, done: 1'b0};
        tbl[2] = '{stall: 1'b0, instr: 4'b0010, valid: 1'b1, pc: 4'd2, busy: 1'b1, done: 1'b0};
        tbl[3] = '{stall: 1'b0, instr: 4'b0011, valid: 1'b1, pc: 4'd3, busy: 1'b0, done: 1'b0};
        tbl[4] = '{stall: 1'b0, instr: 4'b0000, valid: 1'b0, pc: 4'd3, busy: 1'b0, done: 1'b1};
        tbl[5] = '{stall: 1'b0, instr: 4'b0000, valid: 1'b0, pc: 4'd3, busy: 1'b0, done: 1'b0};
        bus.start    = 1'b1;
        bus.prog_len = 5'd3;
        step();
        bus.start = 1'b0;
        chk("tbl_start_busy", 32'(bus.busy), 1);
        for (int i = 0; i < 6; i++) begin
            bus.stall = tbl[i].stall;
            step();
            chk($sformatf("tbl%0d_instr", i), 32'(bus.instruction), 32'(tbl[i].instr));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_pc", i), 32'(bus.pc), 32'(tbl[i].pc));
            chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_done", i), 32'(bus.done), 32'(tbl[i].done));
        end
        bus.stall = 1'b0;

        // Full depth, clamp, and zero length
        for (int a = 0; a < 16; a++) begin
            write_mem(4'(a), 4'($urandom));
        end
        do_run(16, 0, 1'b0, 1'b0);
        do_run(20, 0, 1'b0, 1'b0);
        do_run(0, 0, 1'b0, 1'b0);

        // Reset mid-run, then replay from mem[0]
        bus.start    = 1'b1;
        bus.prog_len = 5'd8;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("mid_word1", 32'(bus.instruction), 32'(exp_mem[1]));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_instr", 32'(bus.instruction), 0);
        chk("mid_rst_valid", 32'(bus.instr_valid), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_pc", 32'(bus.pc), 0);
        step();
        chk("mid_rst_stays_idle", 32'(bus.busy), 0);
        do_run(8, 0, 1'b0, 1'b0);

        // Lockout: writes and starts during RUN are ignored; later run sees originals
        do_run(8, 20, 1'b1, 1'b0);
        do_run(8, 0, 1'b0, 1'b0);

        // Write together with start in IDLE is visible to the first fetch
        do_run(4, 0, 1'b0, 1'b1);

        // Randomized programs
        for (int r = 0; r < 12; r++) begin
            for (int w = 0; w < 4; w++) begin
                write_mem(4'($urandom), 4'($urandom));
            end
            do_run($urandom_range(0, 20), $urandom_range(0, 50), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
